// File: rtl/serial_frame_sequencer.sv
// Frame controller upstream of the MUX-link serializer: command handshake, load/shift
// strobes, divided sclk, active-low csN, MSB-first sdi capture. Option macro: FRAME_CHECK_EN.
module serial_frame_sequencer #(
  parameter int WIDTH   = 5,
  parameter int CLK_DIV = 4,
  parameter int GAP     = 2
) (
  input  logic             CLK,
  input  logic             resetN,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [WIDTH-1:0] cmdData,
  output logic [WIDTH-1:0] txWord,
  output logic             loadData,
  output logic             clockEnable,
  output logic             sclk,
  output logic             csN,
  input  logic             sdi,
  output logic [WIDTH-1:0] rspData,
  output logic             rspValid,
  output logic             busy
`ifdef FRAME_CHECK_EN
  ,
  output logic             rspMismatch
`endif
);

  localparam int DIV_W = ($clog2(2 * CLK_DIV) < 1) ? 1 : $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_GAP
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] divCnt;
  logic [BIT_W-1:0] bitCnt;
  logic [GAP_W-1:0] gapCnt;
  logic [WIDTH-1:0] rxShift;

  logic             divWrap;
  logic             lastBitDone;
  logic [DIV_W-1:0] divNext;
  logic [BIT_W-1:0] bitNext;

  // Position within the frame one cycle ahead, so every strobe can be registered.
  always_comb begin
    divWrap     = (divCnt == DIV_LAST);
    divNext     = divWrap ? '0 : divCnt + 1'b1;
    bitNext     = divWrap ? bitCnt + 1'b1 : bitCnt;
    lastBitDone = divWrap && (bitCnt == BIT_LAST);
  end

  // NOTE: all state and outputs use non-blocking assignments so every register samples
  // pre-edge values; blocking here would make order-dependent, simulation-only behaviour.
  always_ff @(posedge CLK) begin
    if (!resetN) begin
      state       <= ST_IDLE;
      cmdReady    <= 1'b0;
      txWord      <= '0;
      loadData    <= 1'b0;
      clockEnable <= 1'b0;
      sclk        <= 1'b0;
      csN         <= 1'b1;
      rspData     <= '0;
      rspValid    <= 1'b0;
      busy        <= 1'b0;
      divCnt      <= '0;
      bitCnt      <= '0;
      gapCnt      <= '0;
      rxShift     <= '0;
`ifdef FRAME_CHECK_EN
      rspMismatch <= 1'b0;
`endif
    end else begin
      loadData    <= 1'b0;
      clockEnable <= 1'b0;
      rspValid    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cmdValid && cmdReady) begin
            txWord   <= cmdData;
            cmdReady <= 1'b0;
            loadData <= 1'b1;
            csN      <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_LOAD;
          end else begin
            cmdReady <= 1'b1;
          end
        end

        ST_LOAD: begin
          divCnt <= '0;
          bitCnt <= '0;
          sclk   <= 1'b0;
          state  <= ST_SHIFT;
        end

        ST_SHIFT: begin
          // Capture on the edge where sclk rises, mid bit period, while sdi is settled.
          if (divCnt == DIV_PRE) begin
            rxShift <= {rxShift[WIDTH-2:0], sdi};
          end
          if (lastBitDone) begin
            rspData  <= rxShift;
            rspValid <= 1'b1;
            csN      <= 1'b1;
            sclk     <= 1'b0;
            divCnt   <= '0;
            bitCnt   <= '0;
`ifdef FRAME_CHECK_EN
            rspMismatch <= (rxShift != txWord);
`endif
            state    <= ST_LATCH;
          end else begin
            divCnt      <= divNext;
            bitCnt      <= bitNext;
            sclk        <= (divNext >= DIV_HALF);
            clockEnable <= (divNext == DIV_LAST) && (bitNext != BIT_LAST);
          end
        end

        ST_LATCH: begin
          gapCnt <= '0;
          if (GAP == 0) begin
            busy     <= 1'b0;
            cmdReady <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            state <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (gapCnt == GAP_LAST) begin
            busy     <= 1'b0;
            cmdReady <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            gapCnt <= gapCnt + 1'b1;
          end
        end

        default: begin
          csN   <= 1'b1;
          sclk  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_sequencer.sv
// Directed bench for serial_frame_sequencer: default instance plus CLK_DIV=1/GAP=0 instance.
module tb_serial_frame_sequencer;

  localparam int W = 5;
  localparam int D = 4;
  localparam int G = 2;
  localparam int LOAD_AT  = 1;
  localparam int RV_AT    = 2 + 2 * W * D;
  localparam int READY_AT = 3 + 2 * W * D + G;
  localparam int CS_LOW   = 1 + 2 * W * D;

  logic CLK = 1'b0;
  logic resetN = 1'b0;
  logic cmdValid = 1'b0;
  logic [W-1:0] cmdData = '0;
  logic loop = 1'b0;
  logic sdiConst = 1'b0;
  logic sdi;
  logic cmdReady, loadData, clockEnable, sclk, csN, rspValid, busy;
  logic [W-1:0] txWord, rspData;

  logic cmdValidF = 1'b0;
  logic [W-1:0] cmdDataF = '0;
  logic sdiF = 1'b0;
  logic cmdReadyF, loadDataF, clockEnableF, sclkF, csNF, rspValidF, busyF;
  logic [W-1:0] txWordF, rspDataF;
`ifdef FRAME_CHECK_EN
  logic rspMismatch, rspMismatchF;
`endif

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  serial_frame_sequencer #(.WIDTH(W), .CLK_DIV(D), .GAP(G)) dut (
    .CLK(CLK), .resetN(resetN), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdData(cmdData), .txWord(txWord), .loadData(loadData), .clockEnable(clockEnable),
    .sclk(sclk), .csN(csN), .sdi(sdi), .rspData(rspData), .rspValid(rspValid),
    .busy(busy)
`ifdef FRAME_CHECK_EN
    , .rspMismatch(rspMismatch)
`endif
  );

  serial_frame_sequencer #(.WIDTH(W), .CLK_DIV(1), .GAP(0)) dutFast (
    .CLK(CLK), .resetN(resetN), .cmdValid(cmdValidF), .cmdReady(cmdReadyF),
    .cmdData(cmdDataF), .txWord(txWordF), .loadData(loadDataF), .clockEnable(clockEnableF),
    .sclk(sclkF), .csN(csNF), .sdi(sdiF), .rspData(rspDataF), .rspValid(rspValidF),
    .busy(busyF)
`ifdef FRAME_CHECK_EN
    , .rspMismatch(rspMismatchF)
`endif
  );

  // External serializer model fed by the sequencer strobes, for loopback frames.
  logic [W-1:0] serReg;
  always @(posedge CLK) begin
    if (loadData) serReg <= txWord;
    else if (clockEnable) serReg <= {serReg[W-2:0], 1'b0};
  end
  assign sdi = loop ? serReg[W-1] : sdiConst;

  typedef struct {
    logic [W-1:0] data;
    logic         loop;
    logic         sdiVal;
    logic         pulseMid;
    logic [W-1:0] expRsp;
    logic         expMis;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitReady(input bit fast);
    int n;
    n = 0;
    while (((fast ? cmdReadyF : cmdReady) !== 1'b1) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check(fast ? "ready_wait_fast" : "ready_wait", int'(fast ? cmdReadyF : cmdReady), 1);
  endtask

  task automatic runFrame(input vec_t v, input int idx);
    int loadCnt, loadAt, ceCnt, riseCnt, csLow, rvCnt, rvAt, readyAt;
    logic prevSclk, misCap;
    logic [W-1:0] rspCap, txAt;
    loadCnt = 0; loadAt = -1; ceCnt = 0; riseCnt = 0; csLow = 0;
    rvCnt = 0; rvAt = -1; readyAt = -1; prevSclk = 1'b0; misCap = 1'b0;
    rspCap = '0; txAt = '0;
    waitReady(1'b0);
    cmdData = v.data; cmdValid = 1'b1; loop = v.loop; sdiConst = v.sdiVal;
    @(posedge CLK);
    for (int n = 1; n <= 50; n++) begin
      @(negedge CLK);
      if (n == 1) cmdValid = 1'b0;
      if (v.pulseMid && n == 10) begin cmdValid = 1'b1; cmdData = ~v.data; end
      if (v.pulseMid && n == 11) cmdValid = 1'b0;
      if (loadData) begin loadCnt++; if (loadAt < 0) loadAt = n; end
      if (clockEnable) ceCnt++;
      if (sclk && !prevSclk) riseCnt++;
      prevSclk = sclk;
      if (!csN) csLow++;
      if (rspValid) begin
        rvCnt++;
        if (rvAt < 0) rvAt = n;
        rspCap = rspData;
`ifdef FRAME_CHECK_EN
        misCap = rspMismatch;
`endif
      end
      if (cmdReady && readyAt < 0) readyAt = n;
      if (n == 30) txAt = txWord;
    end
    check($sformatf("v%0d_load_cnt", idx), loadCnt, 1);
    check($sformatf("v%0d_load_at", idx), loadAt, LOAD_AT);
    check($sformatf("v%0d_ce_cnt", idx), ceCnt, W - 1);
    check($sformatf("v%0d_sclk_rises", idx), riseCnt, W);
    check($sformatf("v%0d_csn_low", idx), csLow, CS_LOW);
    check($sformatf("v%0d_rv_cnt", idx), rvCnt, 1);
    check($sformatf("v%0d_rv_at", idx), rvAt, RV_AT);
    check($sformatf("v%0d_ready_at", idx), readyAt, READY_AT);
    check($sformatf("v%0d_rsp", idx), int'(rspCap), int'(v.expRsp));
    check($sformatf("v%0d_txword", idx), int'(txAt), int'(v.data));
    check($sformatf("v%0d_rsp_hold", idx), int'(rspData), int'(v.expRsp));
    check($sformatf("v%0d_busy_end", idx), int'(busy), 0);
`ifdef FRAME_CHECK_EN
    check($sformatf("v%0d_mismatch", idx), int'(misCap), int'(v.expMis));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int riseCnt, riseAt, rvCnt, csHigh;
    logic prevSclk;
    int loadCnt, load1, load2, rvAtF1, rvAtF2, rvCntF, overlap, toggles, readyAtF;
    logic prevSclkF;
    logic [W-1:0] rspF1, txF;

    vecs[0] = '{data: 5'b10110, loop: 1'b1, sdiVal: 1'b0, pulseMid: 1'b0, expRsp: 5'b10110, expMis: 1'b0};
    vecs[1] = '{data: 5'b00000, loop: 1'b0, sdiVal: 1'b1, pulseMid: 1'b0, expRsp: 5'b11111, expMis: 1'b1};
    vecs[2] = '{data: 5'b01001, loop: 1'b1, sdiVal: 1'b0, pulseMid: 1'b0, expRsp: 5'b01001, expMis: 1'b0};
    vecs[3] = '{data: 5'b11111, loop: 1'b0, sdiVal: 1'b0, pulseMid: 1'b0, expRsp: 5'b00000, expMis: 1'b1};
    vecs[4] = '{data: 5'b10110, loop: 1'b1, sdiVal: 1'b0, pulseMid: 1'b1, expRsp: 5'b10110, expMis: 1'b0};
    vecs[5] = '{data: 5'b00001, loop: 1'b0, sdiVal: 1'b0, pulseMid: 1'b0, expRsp: 5'b00000, expMis: 1'b1};
    vecs[6] = '{data: 5'b00000, loop: 1'b0, sdiVal: 1'b0, pulseMid: 1'b0, expRsp: 5'b00000, expMis: 1'b0};

    // Reset state.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_cmdReady", int'(cmdReady), 0);
    check("rst_txWord", int'(txWord), 0);
    check("rst_loadData", int'(loadData), 0);
    check("rst_clockEnable", int'(clockEnable), 0);
    check("rst_sclk", int'(sclk), 0);
    check("rst_csN", int'(csN), 1);
    check("rst_rspData", int'(rspData), 0);
    check("rst_rspValid", int'(rspValid), 0);
    check("rst_busy", int'(busy), 0);
`ifdef FRAME_CHECK_EN
    check("rst_mismatch", int'(rspMismatch), 0);
`endif
    resetN = 1'b1;
    @(negedge CLK);
    check("ready_after_rst", int'(cmdReady), 1);

    foreach (vecs[i]) runFrame(vecs[i], i);

    // Reset mid-frame at the third sclk rise.
    waitReady(1'b0);
    cmdData = 5'b10110; cmdValid = 1'b1; loop = 1'b1;
    @(posedge CLK);
    riseCnt = 0; riseAt = -1; prevSclk = 1'b0;
    for (int n = 1; n <= 60 && riseAt < 0; n++) begin
      @(negedge CLK);
      if (n == 1) cmdValid = 1'b0;
      if (sclk && !prevSclk) begin
        riseCnt++;
        if (riseCnt == 3) riseAt = n;
      end
      prevSclk = sclk;
    end
    check("third_rise_at", riseAt, 2 + 2 * 2 * D + D);
    resetN = 1'b0;
    @(negedge CLK);
    resetN = 1'b1;
    check("abort_csN", int'(csN), 1);
    check("abort_sclk", int'(sclk), 0);
    check("abort_rspValid", int'(rspValid), 0);
    check("abort_rspData", int'(rspData), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_ready_low", int'(cmdReady), 0);
    @(negedge CLK);
    check("abort_ready_high", int'(cmdReady), 1);
    rvCnt = 0; csHigh = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge CLK);
      if (rspValid) rvCnt++;
      if (csN) csHigh++;
    end
    check("abort_no_rsp", rvCnt, 0);
    check("abort_cs_idle", csHigh, 60);

    // Fast instance: CLK_DIV=1, GAP=0, cmdValid held across two frames.
    waitReady(1'b1);
    cmdDataF = 5'b10011; cmdValidF = 1'b1; sdiF = 1'b1;
    @(posedge CLK);
    loadCnt = 0; load1 = -1; load2 = -1; rvAtF1 = -1; rvAtF2 = -1; rvCntF = 0;
    overlap = 0; toggles = 0; readyAtF = -1; prevSclkF = 1'b0; rspF1 = '0; txF = '0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge CLK);
      if (n == 2) cmdDataF = 5'b01100;
      if (n == 14) cmdValidF = 1'b0;
      if (loadDataF) begin
        loadCnt++;
        if (load1 < 0) load1 = n; else if (load2 < 0) load2 = n;
      end
      if (rspValidF) begin
        rvCntF++;
        if (rvAtF1 < 0) begin rvAtF1 = n; rspF1 = rspDataF; end
        else if (rvAtF2 < 0) rvAtF2 = n;
      end
      if (loadDataF && rspValidF) overlap++;
      if (n >= 3 && n <= 11 && sclkF != prevSclkF) toggles++;
      prevSclkF = sclkF;
      if (cmdReadyF && readyAtF < 0) readyAtF = n;
      if (n == 20) txF = txWordF;
    end
    check("fast_load_cnt", loadCnt, 2);
    check("fast_load1_at", load1, 1);
    check("fast_load2_at", load2, 14);
    check("fast_ready_at", readyAtF, 13);
    check("fast_rv_cnt", rvCntF, 2);
    check("fast_rv1_at", rvAtF1, 12);
    check("fast_rv2_at", rvAtF2, 25);
    check("fast_overlap", overlap, 0);
    check("fast_sclk_toggles", toggles, 9);
    check("fast_rsp", int'(rspF1), 31);
    check("fast_txword2", int'(txF), int'(5'b01100));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
